// File: rtl/system_nios2_qsys_0_oci_dct_ctrl_if.sv
// ---------------------------------------------------------------------------
// system_nios2_qsys_0_oci_dct_ctrl_if
// Bundles the atom input and frame output handshakes of the DCT controller.
//   atom_valid  : an atom is presented this cycle
//   atom[1:0]   : compressed trace atom
//   frame_valid : the output frame register holds a frame
//   frame_ready : downstream writer accepts the frame
//   frame_data  : {2'b01, count[3:0], buffer[29:0]}
// master: surroundings (atom source + trace writer); slave: the controller.
// ---------------------------------------------------------------------------
interface system_nios2_qsys_0_oci_dct_ctrl_if;
   logic        atom_valid;
   logic [1:0]  atom;
   logic        frame_valid;
   logic        frame_ready;
   logic [35:0] frame_data;

   modport master (
      output atom_valid, atom, frame_ready,
      input  frame_valid, frame_data
   );

   modport slave (
      input  atom_valid, atom, frame_ready,
      output frame_valid, frame_data
   );
endinterface

// File: rtl/system_nios2_qsys_0_oci_dct_ctrl.sv
// ---------------------------------------------------------------------------
// system_nios2_qsys_0_oci_dct_ctrl
// Packs 2-bit trace atoms into a 30-bit buffer (newest atom in [1:0]) and
// emits the buffer as a 36-bit frame when it fills, on flush, on trace
// disable, or after TIMEOUT idle cycles with atoms pending.
// Ports:
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   trc_on        : trace enable; atoms ignored while low
//   flush_req     : one-cycle request to emit pending atoms
//   overflow_clr  : clears the sticky overflow flag (a set wins)
//   bus           : atom input + frame output handshakes (slave modport)
//   dct_buffer    : live packing buffer
//   dct_count     : atoms held in dct_buffer (0..15)
//   overflow      : sticky, set when an atom is dropped
// ---------------------------------------------------------------------------
module system_nios2_qsys_0_oci_dct_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     trc_on,
   input  logic                                     flush_req,
   input  logic                                     overflow_clr,
   system_nios2_qsys_0_oci_dct_ctrl_if.slave        bus,
   output logic [29:0]                              dct_buffer,
   output logic [3:0]                               dct_count,
   output logic                                     overflow
);

   localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

   logic [29:0] buffer_q;
   logic [3:0]  count_q;
   logic [7:0]  idle_q;
   logic        pending_q;
   logic        trc_q;
   logic        fall_q;
   logic        overflow_q;
   logic        frame_valid_q;
   logic [35:0] frame_data_q;

   logic        free;
   logic        arrive;
   logic        full;
   logic        accept;
   logic        wrap;
   logic        drop;
   logic [29:0] post_buffer;
   logic [3:0]  post_count;
   logic        trigger;
   logic        emit;
   logic        load;

   always_comb begin
      free        = !frame_valid_q || bus.frame_ready;
      arrive      = trc_on && bus.atom_valid;
      full        = (count_q == 4'd15);
      accept      = arrive && !full;
      // A full buffer meeting a free output register ships the 15 held atoms
      // and the arriving atom seeds the next buffer instead of being dropped.
      wrap        = arrive && full && free;
      drop        = arrive && full && !free;
      post_buffer = accept ? {buffer_q[27:0], bus.atom} : buffer_q;
      post_count  = accept ? count_q + 4'd1 : count_q;
      trigger     = (post_count == 4'd15) || flush_req || fall_q ||
                    (idle_q == IDLE_LIMIT) || pending_q;
      emit        = trigger && (post_count != 4'd0);
      load        = emit && free;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buffer_q      <= '0;
         count_q       <= '0;
         idle_q        <= '0;
         pending_q     <= 1'b0;
         trc_q         <= 1'b0;
         fall_q        <= 1'b0;
         overflow_q    <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_data_q  <= '0;
      end else begin
         // Falling trc_on is registered so its flush lands one edge later.
         trc_q  <= trc_on;
         fall_q <= trc_q && !trc_on;

         if (load) begin
            frame_data_q  <= {2'b01, post_count, post_buffer};
            frame_valid_q <= 1'b1;
            pending_q     <= 1'b0;
            buffer_q      <= wrap ? {28'd0, bus.atom} : '0;
            count_q       <= wrap ? 4'd1 : 4'd0;
         end else begin
            if (bus.frame_ready) begin
               frame_valid_q <= 1'b0;
            end
            if (emit) begin
               pending_q <= 1'b1;
            end
            buffer_q <= post_buffer;
            count_q  <= post_count;
         end

         if (drop) begin
            overflow_q <= 1'b1;
         end else if (overflow_clr) begin
            overflow_q <= 1'b0;
         end

         // Saturating so a long busy stall cannot wrap back onto the limit.
         if (accept || load) begin
            idle_q <= '0;
         end else if (trc_on && (count_q != 4'd0) && !bus.atom_valid &&
                      (idle_q != 8'hFF)) begin
            idle_q <= idle_q + 8'd1;
         end
      end
   end

   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_data  = frame_data_q;
   assign dct_buffer      = buffer_q;
   assign dct_count       = count_q;
   assign overflow        = overflow_q;

endmodule
